// File: rtl/mkio_rx_assembler.sv
// MIL-STD-1553 (MKIO) receive-side message assembler.
// Turns the per-word handshake from the hi_1575 receiver into complete
// messages: a command word followed by its data words, held in a 33-word
// buffer until the consumer acknowledges them. Incomplete, interrupted or
// surplus words are counted in a saturating drop counter.
module mkio_rx_assembler #(
  parameter int GAP_TIMEOUT = 2500,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                  clock_100,
  input  logic                  reset,
  input  logic [15:0]           data_rx,
  input  logic [1:0]            data_received_rx,
  input  logic                  cha_chb_rx,
  input  logic                  msg_ack,
  input  logic [5:0]            rd_addr,
  output logic [15:0]           rd_data,
  output logic                  msg_valid,
  output logic [15:0]           msg_cmd,
  output logic [5:0]            msg_len,
  output logic                  msg_channel,
  output logic [1:0]            msg_status,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam int SUM_W = ((DROP_CNT_W > 6) ? DROP_CNT_W : 6) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_CHANNEL = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_t;

  // Number of data words announced by a command word. Mode codes
  // (subaddress 0 or 31) carry at most one data word, flagged by bit 4;
  // for ordinary subaddresses a word count of 0 means 32.
  function automatic logic [5:0] word_count(input logic [15:0] cmd);
    if (cmd[9:5] == 5'd0 || cmd[9:5] == 5'd31)
      return {5'd0, cmd[4]};
    else if (cmd[4:0] == 5'd0)
      return 6'd32;
    else
      return {1'b0, cmd[4:0]};
  endfunction

  // Add to the drop counter, pinning at all ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                   input logic [5:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum[SUM_W-1:DROP_CNT_W] != '0)
      return '1;
    else
      return sum[DROP_CNT_W-1:0];
  endfunction

  logic            rx_vld_p0;
  logic            strobe;
  logic            rx_sync;
  logic [5:0]      rx_wc;

  state_t          state;
  state_t          state_nxt;

  logic [15:0]     cmd_q;
  logic [5:0]      exp_q;
  logic [5:0]      idx_q;
  logic [5:0]      idx_inc;
  logic            chan_q;
  logic [GAP_W-1:0] gap_q;

  logic [15:0]     buf_mem [0:32];

  logic            cmd_accept;
  logic            data_accept;
  logic            load_msg;
  logic [5:0]      drop_amt;
  logic [5:0]      ld_len;
  logic [1:0]      ld_status;
  logic [15:0]     ld_cmd;
  logic            ld_chan;

  // The receiver pulls bit0 low while a word is being read out and raises
  // it when the word is ready; the rising edge marks exactly one new word.
  assign strobe  = data_received_rx[0] & ~rx_vld_p0;
  assign rx_sync = data_received_rx[1];
  assign rx_wc   = word_count(data_rx);
  assign idx_inc = idx_q + 6'd1;

  // Edge-detect register; resets high so a level already high is not a word.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) rx_vld_p0 <= 1'b1;
    else       rx_vld_p0 <= data_received_rx[0];
  end

  // State register.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (strobe && rx_sync)
          state_nxt = (rx_wc == 6'd0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (strobe && rx_sync)
          state_nxt = (rx_wc == 6'd0) ? DONE : COLLECT;
        else if (strobe && (cha_chb_rx != chan_q))
          state_nxt = DONE;
        else if (strobe) begin
          if (idx_inc == exp_q) state_nxt = DONE;
        end else if (gap_q == GAP_LAST)
          state_nxt = DONE;
      end
      DONE: begin
        if (msg_valid && msg_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state actions: word acceptance, drop accounting and message hand-off.
  always_comb begin
    cmd_accept  = 1'b0;
    data_accept = 1'b0;
    load_msg    = 1'b0;
    drop_amt    = 6'd0;
    ld_len      = idx_q;
    ld_status   = ST_OK;
    ld_cmd      = cmd_q;
    ld_chan     = chan_q;
    case (state)
      IDLE: begin
        if (strobe && rx_sync) begin
          cmd_accept = 1'b1;
          if (rx_wc == 6'd0) begin
            load_msg = 1'b1;
            ld_len   = 6'd0;
            ld_cmd   = data_rx;
            ld_chan  = cha_chb_rx;
          end
        end else if (strobe) begin
          drop_amt = 6'd1;
        end
      end
      COLLECT: begin
        if (strobe && rx_sync) begin
          // A new command abandons the partial message: the old command
          // plus every data word collected so far is lost.
          cmd_accept = 1'b1;
          drop_amt   = idx_inc;
          if (rx_wc == 6'd0) begin
            load_msg = 1'b1;
            ld_len   = 6'd0;
            ld_cmd   = data_rx;
            ld_chan  = cha_chb_rx;
          end
        end else if (strobe && (cha_chb_rx != chan_q)) begin
          drop_amt  = 6'd1;
          load_msg  = 1'b1;
          ld_status = ST_CHANNEL;
        end else if (strobe) begin
          data_accept = 1'b1;
          if (idx_inc == exp_q) begin
            load_msg = 1'b1;
            ld_len   = idx_inc;
          end
        end else if (gap_q == GAP_LAST) begin
          load_msg  = 1'b1;
          ld_status = ST_TIMEOUT;
        end
      end
      DONE: begin
        if (strobe) drop_amt = 6'd1;
      end
      default: ;
    endcase
  end

  // Control registers: gap timer, message descriptor and drop counter.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      gap_q       <= '0;
      msg_valid   <= 1'b0;
      msg_cmd     <= 16'h0;
      msg_len     <= 6'd0;
      msg_channel <= 1'b0;
      msg_status  <= 2'd0;
      drop_count  <= '0;
    end else begin
      if (state != COLLECT || strobe) gap_q <= '0;
      else                            gap_q <= gap_q + 1'b1;

      if (load_msg) begin
        msg_valid   <= 1'b1;
        msg_cmd     <= ld_cmd;
        msg_len     <= ld_len;
        msg_channel <= ld_chan;
        msg_status  <= ld_status;
      end else if (msg_valid && msg_ack) begin
        msg_valid <= 1'b0;
      end

      if (drop_amt != 6'd0) drop_count <= sat_add(drop_count, drop_amt);
    end
  end

  // Working registers for the message being collected.
  always_ff @(posedge clock_100) begin
    if (cmd_accept) begin
      cmd_q  <= data_rx;
      exp_q  <= rx_wc;
      chan_q <= cha_chb_rx;
      idx_q  <= 6'd0;
    end else if (data_accept) begin
      idx_q  <= idx_inc;
    end
  end

  // Message buffer: command at address 0, data words at 1..32.
  always_ff @(posedge clock_100) begin
    if (cmd_accept)  buf_mem[0]       <= data_rx;
    if (data_accept) buf_mem[idx_inc] <= data_rx;
  end

  // Registered read port; addresses past the buffer read as zero.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset)                rd_data <= 16'h0;
    else if (rd_addr <= 6'd32) rd_data <= buf_mem[rd_addr];
    else                      rd_data <= 16'h0;
  end

endmodule

// File: tb/tb_mkio_rx_assembler.sv
// Directed testbench for mkio_rx_assembler: table of complete messages
// followed by hand-written timeout, channel, restart, overrun and reset cases.
module tb_mkio_rx_assembler;

  localparam int GAP  = 2500;
  localparam int DCW  = 8;

  logic           clock_100 = 1'b0;
  logic           reset;
  logic [15:0]    data_rx;
  logic [1:0]     data_received_rx;
  logic           cha_chb_rx;
  logic           msg_ack;
  logic [5:0]     rd_addr;
  logic [15:0]    rd_data;
  logic           msg_valid;
  logic [15:0]    msg_cmd;
  logic [5:0]     msg_len;
  logic           msg_channel;
  logic [1:0]     msg_status;
  logic [DCW-1:0] drop_count;

  int n_vec = 0;
  int n_bad = 0;

  mkio_rx_assembler #(.GAP_TIMEOUT(GAP), .DROP_CNT_W(DCW)) dut (
    .clock_100        (clock_100),
    .reset            (reset),
    .data_rx          (data_rx),
    .data_received_rx (data_received_rx),
    .cha_chb_rx       (cha_chb_rx),
    .msg_ack          (msg_ack),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .msg_valid        (msg_valid),
    .msg_cmd          (msg_cmd),
    .msg_len          (msg_len),
    .msg_channel      (msg_channel),
    .msg_status       (msg_status),
    .drop_count       (drop_count)
  );

  always #5 clock_100 = ~clock_100;

  typedef struct {
    logic [15:0] cmd;
    logic        ch;
    int          ndata;
    logic [15:0] base;
    logic [15:0] step;
    int          exp_len;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic sync, input logic ch);
    @(negedge clock_100);
    data_received_rx[0] = 1'b0;
    data_rx             = w;
    data_received_rx[1] = sync;
    cha_chb_rx          = ch;
    @(negedge clock_100);
    data_received_rx[0] = 1'b1;
    @(negedge clock_100);
    @(negedge clock_100);
  endtask

  task automatic read_chk(input string name, input logic [5:0] a, input logic [15:0] exp);
    @(negedge clock_100);
    rd_addr = a;
    @(negedge clock_100);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (msg_valid !== 1'b1 && n < budget) begin
      @(negedge clock_100);
      n++;
    end
    check("msg_valid_rise", 32'(msg_valid), 32'd1);
  endtask

  task automatic do_ack();
    @(negedge clock_100);
    msg_ack = 1'b1;
    @(negedge clock_100);
    msg_ack = 1'b0;
    check("msg_valid_clear", 32'(msg_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clock_100);
    reset = 1'b1;
    @(negedge clock_100);
    @(negedge clock_100);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] w;

    tbl[0] = '{16'h0843, 1'b0, 3,  16'h1111, 16'h1111, 3};
    tbl[1] = '{16'h0820, 1'b0, 32, 16'hA000, 16'h0001, 32};
    tbl[2] = '{16'h0011, 1'b0, 1,  16'hBEEF, 16'h0000, 1};
    tbl[3] = '{16'h0002, 1'b0, 0,  16'h0000, 16'h0000, 0};
    tbl[4] = '{16'h03F0, 1'b1, 1,  16'h5A5A, 16'h0000, 1};
    tbl[5] = '{16'h0C22, 1'b1, 2,  16'h0F0F, 16'h1010, 2};

    reset            = 1'b1;
    data_rx          = 16'h0;
    data_received_rx = 2'b01;
    cha_chb_rx       = 1'b0;
    msg_ack          = 1'b0;
    rd_addr          = 6'd0;

    // Reset state
    @(negedge clock_100);
    @(negedge clock_100);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clock_100);
    @(negedge clock_100);
    check("rst_msg_valid",  32'(msg_valid),   32'd0);
    check("rst_msg_cmd",    32'(msg_cmd),     32'd0);
    check("rst_msg_len",    32'(msg_len),     32'd0);
    check("rst_msg_status", 32'(msg_status),  32'd0);
    check("rst_msg_chan",   32'(msg_channel), 32'd0);
    check("rst_drop",       32'(drop_count),  32'd0);

    // Table of complete messages
    for (int v = 0; v < 6; v++) begin
      send_word(tbl[v].cmd, 1'b1, tbl[v].ch);
      w = tbl[v].base;
      for (int i = 0; i < tbl[v].ndata; i++) begin
        send_word(w, 1'b0, tbl[v].ch);
        w = w + tbl[v].step;
      end
      wait_valid(8);
      check($sformatf("v%0d_len", v),    32'(msg_len),     32'(tbl[v].exp_len));
      check($sformatf("v%0d_status", v), 32'(msg_status),  32'd0);
      check($sformatf("v%0d_cmd", v),    32'(msg_cmd),     32'(tbl[v].cmd));
      check($sformatf("v%0d_chan", v),   32'(msg_channel), 32'(tbl[v].ch));
      check($sformatf("v%0d_drop", v),   32'(drop_count),  32'd0);
      read_chk($sformatf("v%0d_rd0", v), 6'd0, tbl[v].cmd);
      w = tbl[v].base;
      for (int i = 1; i <= tbl[v].ndata; i++) begin
        read_chk($sformatf("v%0d_rd%0d", v, i), 6'(i), w);
        w = w + tbl[v].step;
      end
      check($sformatf("v%0d_stable_len", v), 32'(msg_len), 32'(tbl[v].exp_len));
      do_ack();
    end
    read_chk("rd_oob_33", 6'd33, 16'h0);
    read_chk("rd_oob_63", 6'd63, 16'h0);

    // Gap timeout after two of four data words
    send_word(16'h0844, 1'b1, 1'b0);
    send_word(16'hAAAA, 1'b0, 1'b0);
    send_word(16'hBBBB, 1'b0, 1'b0);
    repeat (GAP - 10) @(negedge clock_100);
    check("to_early", 32'(msg_valid), 32'd0);
    wait_valid(40);
    check("to_status", 32'(msg_status), 32'd1);
    check("to_len",    32'(msg_len),    32'd2);
    check("to_drop",   32'(drop_count), 32'd0);
    do_ack();

    // Channel switch mid-message
    send_word(16'h0843, 1'b1, 1'b0);
    send_word(16'h1234, 1'b0, 1'b1);
    wait_valid(8);
    check("ch_status", 32'(msg_status),  32'd2);
    check("ch_len",    32'(msg_len),     32'd0);
    check("ch_chan",   32'(msg_channel), 32'd0);
    check("ch_drop",   32'(drop_count),  32'd1);

    // Strobe coinciding with msg_ack is still dropped
    @(negedge clock_100);
    data_received_rx = 2'b10;
    data_rx          = 16'h0843;
    cha_chb_rx       = 1'b0;
    @(negedge clock_100);
    data_received_rx[0] = 1'b1;
    msg_ack             = 1'b1;
    @(negedge clock_100);
    msg_ack = 1'b0;
    check("ackstb_valid", 32'(msg_valid),  32'd0);
    check("ackstb_drop",  32'(drop_count), 32'd2);
    repeat (4) @(negedge clock_100);
    check("ackstb_idle", 32'(msg_valid), 32'd0);

    // Restart on a new command, then overrun and saturation
    pulse_reset();
    check("rs_drop0", 32'(drop_count), 32'd0);
    send_word(16'h0843, 1'b1, 1'b0);
    send_word(16'h7777, 1'b0, 1'b0);
    send_word(16'h0821, 1'b1, 1'b0);
    send_word(16'h5555, 1'b0, 1'b0);
    wait_valid(8);
    check("rs_cmd",    32'(msg_cmd),    32'h0821);
    check("rs_len",    32'(msg_len),    32'd1);
    check("rs_status", 32'(msg_status), 32'd0);
    check("rs_drop",   32'(drop_count), 32'd2);
    read_chk("rs_rd1", 6'd1, 16'h5555);
    for (int i = 0; i < 3; i++) send_word(16'hDEAD, 1'b0, 1'b0);
    check("ov_drop5", 32'(drop_count), 32'd5);
    check("ov_cmd",   32'(msg_cmd),    32'h0821);
    check("ov_len",   32'(msg_len),    32'd1);
    for (int i = 0; i < 250; i++) send_word(16'h0001, 1'b0, 1'b0);
    check("sat_255a", 32'(drop_count), 32'd255);
    for (int i = 0; i < 10; i++) send_word(16'h0001, 1'b0, 1'b0);
    check("sat_255b", 32'(drop_count), 32'd255);
    do_ack();

    // Asynchronous reset in the middle of a message
    send_word(16'h0843, 1'b1, 1'b0);
    send_word(16'h4321, 1'b0, 1'b0);
    rd_addr = 6'd1;
    @(negedge clock_100);
    check("ar_rd_pre", 32'(rd_data), 32'h4321);
    #3 reset = 1'b1;
    #1;
    check("ar_drop",   32'(drop_count), 32'd0);
    check("ar_valid",  32'(msg_valid),  32'd0);
    check("ar_rd",     32'(rd_data),    32'd0);
    check("ar_len",    32'(msg_len),    32'd0);
    check("ar_cmd",    32'(msg_cmd),    32'd0);
    @(negedge clock_100);
    reset = 1'b0;
    repeat (5) @(negedge clock_100);
    check("ar_no_strobe", 32'(drop_count), 32'd0);
    check("ar_valid2",    32'(msg_valid),  32'd0);
    send_word(16'h9999, 1'b0, 1'b0);
    check("ar_idle_drop", 32'(drop_count), 32'd1);
    check("ar_idle_valid", 32'(msg_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
